// File: rtl/img_frame_arbiter.sv
// Two-source frame arbiter: grants the shared processing core to one camera
// stream for a whole frame, forwards it with one cycle of latency and checks its geometry.
module img_frame_arbiter #(
    parameter int IMG_HDISP = 512,
    parameter int IMG_VDISP = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  src_en,
    input  logic        s0_vsync,
    input  logic        s0_href,
    input  logic [7:0]  s0_gray,
    input  logic        s1_vsync,
    input  logic        s1_href,
    input  logic [7:0]  s1_gray,
    output logic        m_vsync,
    output logic        m_href,
    output logic [7:0]  m_gray,
    output logic [1:0]  grant,
    output logic        frame_done,
    output logic        frame_err,
    output logic [15:0] frame_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;

    localparam logic [15:0] HDISP = 16'(IMG_HDISP);
    localparam logic [15:0] VDISP = 16'(IMG_VDISP);

    state_e      state_q, state_d;
    logic [1:0]  vsync_r_q;
    logic        rr_q, rr_d;            // 1: source 1 wins a simultaneous start
    logic        m_vsync_q, m_vsync_d;
    logic        m_href_q, m_href_d;
    logic [7:0]  m_gray_q, m_gray_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] pix_q, pix_d;
    logic [15:0] line_q, line_d;
    logic        line_err_q, line_err_d;

    logic        sel_vsync, sel_href;
    logic        fs0, fs1, href_fall;
    logic [15:0] line_nx;
    logic        line_err_nx;

    always_comb begin
        sel_vsync   = (state_q == GRANT1) ? s1_vsync : s0_vsync;
        sel_href    = (state_q == GRANT1) ? s1_href  : s0_href;
        fs0         = s0_vsync & ~vsync_r_q[0] & src_en[0];
        fs1         = s1_vsync & ~vsync_r_q[1] & src_en[1];
        // m_href_q holds the granted source's href from the previous cycle
        href_fall   = m_href_q & ~sel_href;
        line_nx     = line_q + {15'd0, href_fall};
        line_err_nx = line_err_q | (href_fall & (pix_q != HDISP));

        state_d    = state_q;
        rr_d       = rr_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        cnt_d      = cnt_q;
        pix_d      = pix_q;
        line_d     = line_q;
        line_err_d = line_err_q;

        case (state_q)
            IDLE: begin
                if (fs0 && (!fs1 || !rr_q)) begin
                    state_d = GRANT0;
                    rr_d    = 1'b1;
                end else if (fs1) begin
                    state_d = GRANT1;
                    rr_d    = 1'b0;
                end
                if (state_d != IDLE) begin
                    pix_d      = 16'd0;
                    line_d     = 16'd0;
                    line_err_d = 1'b0;
                end
            end
            GRANT0, GRANT1: begin
                if (!sel_vsync) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = line_err_nx | (line_nx != VDISP) | sel_href;
                    cnt_d   = cnt_q + 16'd1;
                end else begin
                    if (href_fall) begin
                        pix_d = 16'd0;
                    end else if (sel_href) begin
                        pix_d = pix_q + 16'd1;
                    end
                    line_d     = line_nx;
                    line_err_d = line_err_nx;
                end
            end
            default: state_d = IDLE;
        endcase

        // Output stage follows the next state so grant and data switch together
        m_vsync_d = 1'b0;
        m_href_d  = 1'b0;
        m_gray_d  = 8'h00;
        if (state_d == GRANT0) begin
            m_vsync_d = s0_vsync;
            m_href_d  = s0_href;
            m_gray_d  = s0_href ? s0_gray : 8'h00;
        end else if (state_d == GRANT1) begin
            m_vsync_d = s1_vsync;
            m_href_d  = s1_href;
            m_gray_d  = s1_href ? s1_gray : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            vsync_r_q  <= 2'b11;
            rr_q       <= 1'b0;
            m_vsync_q  <= 1'b0;
            m_href_q   <= 1'b0;
            m_gray_q   <= 8'h00;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= 16'd0;
            pix_q      <= 16'd0;
            line_q     <= 16'd0;
            line_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            vsync_r_q  <= {s1_vsync, s0_vsync};
            rr_q       <= rr_d;
            m_vsync_q  <= m_vsync_d;
            m_href_q   <= m_href_d;
            m_gray_q   <= m_gray_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            pix_q      <= pix_d;
            line_q     <= line_d;
            line_err_q <= line_err_d;
        end
    end

    assign m_vsync    = m_vsync_q;
    assign m_href     = m_href_q;
    assign m_gray     = m_gray_q;
    assign grant      = {state_q == GRANT1, state_q == GRANT0};
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_img_frame_arbiter.sv
// Bench for img_frame_arbiter with an 8x4 image: a frame-level model (line
// lengths kept in a queue) is checked every cycle, plus hand-computed expectations.
module tb_img_frame_arbiter;

    localparam int H = 8;
    localparam int V = 4;
    localparam int FLEN = 2 + V * 10;   // vsync-high cycles per frame

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  src_en = 2'b11;
    logic        s0_vsync = 1'b0, s0_href = 1'b0;
    logic [7:0]  s0_gray = 8'h00;
    logic        s1_vsync = 1'b0, s1_href = 1'b0;
    logic [7:0]  s1_gray = 8'h00;
    logic        m_vsync, m_href;
    logic [7:0]  m_gray;
    logic [1:0]  grant;
    logic        frame_done, frame_err;
    logic [15:0] frame_cnt;

    img_frame_arbiter #(.IMG_HDISP(H), .IMG_VDISP(V)) dut (
        .clk(clk), .rst_n(rst_n), .src_en(src_en),
        .s0_vsync(s0_vsync), .s0_href(s0_href), .s0_gray(s0_gray),
        .s1_vsync(s1_vsync), .s1_href(s1_href), .s1_gray(s1_gray),
        .m_vsync(m_vsync), .m_href(m_href), .m_gray(m_gray),
        .grant(grant), .frame_done(frame_done), .frame_err(frame_err),
        .frame_cnt(frame_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // ---------------- stimulus generator ----------------
    int cyc = 0;
    int st[2] = '{-1, -1};       // global cycle at which each source's vsync rises
    int bad[2] = '{-1, -1};      // line index sent one pixel short

    task automatic src_sig(input int n, output logic v, output logic h, output logic [7:0] g);
        int t, l, col, w;
        t = cyc - st[n];
        v = 1'b0;
        h = 1'b0;
        g = 8'($urandom_range(0, 255));
        if (st[n] >= 0 && t >= 0 && t < FLEN) begin
            v = 1'b1;
            if (t >= 2) begin
                l = (t - 2) / 10;
                col = (t - 2) % 10;
                w = (l == bad[n]) ? H - 1 : H;
                if (l < V && col < w) begin
                    h = 1'b1;
                    g = 8'(l * 8 + col + n * 128);
                end
            end
        end
    endtask

    task automatic run_cycles(input int n);
        logic v, h;
        logic [7:0] g;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            src_sig(0, v, h, g);
            s0_vsync = v; s0_href = h; s0_gray = g;
            src_sig(1, v, h, g);
            s1_vsync = v; s1_href = h; s1_gray = g;
            cyc++;
        end
    endtask

    // ---------------- behavioural model ----------------
    int          owner, last, curpix;
    logic        ph, bad_fr, ok0, ok1;
    logic [1:0]  pv, vi, hi;
    logic [7:0]  gi[2];
    int          lines[$];
    logic        e_v, e_h, e_d, e_e;
    logic [7:0]  e_g;
    logic [1:0]  e_gr;
    logic [15:0] e_c;

    always @(posedge clk) begin
        vi = {s1_vsync, s0_vsync};
        hi = {s1_href, s0_href};
        gi[0] = s0_gray;
        gi[1] = s1_gray;
        if (!rst_n) begin
            owner = -1; last = -1; pv = 2'b11; curpix = 0; ph = 1'b0;
            e_c = 16'd0; e_d = 1'b0; e_e = 1'b0;
        end else begin
            e_d = 1'b0;
            e_e = 1'b0;
            if (owner < 0) begin
                ok0 = vi[0] && !pv[0] && src_en[0];
                ok1 = vi[1] && !pv[1] && src_en[1];
                if (ok0 && ok1) owner = (last == 0) ? 1 : 0;
                else if (ok0) owner = 0;
                else if (ok1) owner = 1;
                if (owner >= 0) begin
                    last = owner;
                    lines.delete();
                    curpix = 0;
                    ph = hi[owner];
                end
            end else if (!vi[owner]) begin
                if (ph && !hi[owner]) lines.push_back(curpix);
                bad_fr = (lines.size() != V) || hi[owner];
                foreach (lines[i]) if (lines[i] != H) bad_fr = 1'b1;
                e_d = 1'b1;
                e_e = bad_fr;
                e_c = e_c + 16'd1;
                owner = -1;
            end else begin
                if (hi[owner]) curpix++;
                else if (ph) begin
                    lines.push_back(curpix);
                    curpix = 0;
                end
                ph = hi[owner];
            end
            pv = vi;
        end
        e_v = 1'b0; e_h = 1'b0; e_g = 8'h00; e_gr = 2'b00;
        if (owner >= 0) begin
            e_v = vi[owner];
            e_h = hi[owner];
            e_g = hi[owner] ? gi[owner] : 8'h00;
            e_gr = (owner == 0) ? 2'b01 : 2'b10;
        end
    end

    // ---------------- compare, scoreboard and event logs ----------------
    logic        cmp_en = 1'b0;
    logic        sb_en = 1'b0;
    logic [7:0]  exp_q[$];
    logic [7:0]  sb_exp;
    logic [1:0]  prev_gr = 2'b00;
    int          grant_log[$];
    int          done_cnt = 0, err_cnt = 0, href_cnt = 0, mis_err = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if ({m_vsync, m_href, m_gray, grant, frame_done, frame_err, frame_cnt} !==
                {e_v, e_h, e_g, e_gr, e_d, e_e, e_c}) begin
                failures++;
                $display("FAIL cycle_cmp t=%0t got v=%b h=%b g=%h gr=%b d=%b e=%b c=%0d want v=%b h=%b g=%h gr=%b d=%b e=%b c=%0d",
                         $time, m_vsync, m_href, m_gray, grant, frame_done, frame_err, frame_cnt,
                         e_v, e_h, e_g, e_gr, e_d, e_e, e_c);
            end
            if (sb_en && m_href === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_extra got=%h want=none", m_gray);
                end else begin
                    sb_exp = exp_q.pop_front();
                    if (m_gray !== sb_exp) begin
                        failures++;
                        $display("FAIL sb_gray got=%h want=%h", m_gray, sb_exp);
                    end
                end
            end
            if (grant != 2'b00 && prev_gr == 2'b00) grant_log.push_back(int'(grant));
            if (frame_done) done_cnt++;
            if (frame_err) err_cnt++;
            if (frame_err && !frame_done) mis_err++;
            if (m_href) href_cnt++;
            prev_gr = grant;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        grant_log.delete();
        done_cnt = 0; err_cnt = 0; href_cnt = 0; mis_err = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        st = '{-1, -1};
        bad = '{-1, -1};
        run_cycles(3);
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic check_grants(input string name, input int n, input int g0, input int g1);
        check({name, "_ngrant"}, grant_log.size(), n);
        if (n > 0 && grant_log.size() > 0) check({name, "_grant0"}, grant_log[0], g0);
        if (n > 1 && grant_log.size() > 1) check({name, "_grant1"}, grant_log[1], g1);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        do_reset();
        cmp_en = 1'b1;
        check("rst_vsync", int'(m_vsync), 0);
        check("rst_grant", int'(grant), 0);
        check("rst_cnt", int'(frame_cnt), 0);

        // one clean frame from source 0, pixel values checked against a hand list
        for (int l = 0; l < V; l++)
            for (int c = 0; c < H; c++) exp_q.push_back(8'(l * 8 + c));
        sb_en = 1'b1;
        st[0] = cyc + 2;
        run_cycles(50);
        sb_en = 1'b0;
        check("f1_sb_left", exp_q.size(), 0);
        check("f1_done", done_cnt, 1);
        check("f1_err", err_cnt, 0);
        check("f1_cnt", int'(frame_cnt), 1);
        check("f1_href", href_cnt, 32);
        check_grants("f1", 1, 1, 0);

        // simultaneous starts twice: round robin 0 then 1, loser forwards nothing
        do_reset();
        st = '{cyc + 2, cyc + 2};
        run_cycles(50);
        st = '{cyc + 2, cyc + 2};
        run_cycles(50);
        check_grants("rr", 2, 1, 2);
        check("rr_href", href_cnt, 64);
        check("rr_cnt", int'(frame_cnt), 2);

        // source 1 starts while source 0 is busy: dropped, its next frame forwarded
        do_reset();
        st = '{cyc + 2, cyc + 10};
        run_cycles(60);
        check("busy_drop_cnt", int'(frame_cnt), 1);
        st[1] = cyc + 2;
        run_cycles(50);
        check_grants("busy", 2, 1, 2);
        check("busy_cnt", int'(frame_cnt), 2);
        check("busy_href", href_cnt, 64);

        // short line 2: error pulses together with done, count still advances
        do_reset();
        st[0] = cyc + 2;
        bad[0] = 2;
        run_cycles(50);
        check("short_done", done_cnt, 1);
        check("short_err", err_cnt, 1);
        check("short_err_alone", mis_err, 0);
        check("short_cnt", int'(frame_cnt), 1);

        // reset mid-frame with vsync held high: no re-grant until a fresh rise
        do_reset();
        st[0] = cyc + 2;
        run_cycles(20);
        rst_n = 1'b0;
        run_cycles(1);
        rst_n = 1'b1;
        clear_logs();
        check("mid_rst_vsync", int'(m_vsync), 0);
        check("mid_rst_grant", int'(grant), 0);
        check("mid_rst_cnt", int'(frame_cnt), 0);
        run_cycles(30);
        check_grants("mid_rst_hold", 0, 0, 0);
        check("mid_rst_done", done_cnt, 0);
        st[0] = cyc + 2;
        run_cycles(50);
        check_grants("mid_rst_new", 1, 1, 0);
        check("mid_rst_cnt2", int'(frame_cnt), 1);

        // source 0 masked: ignored; source 1 forwarded
        do_reset();
        src_en = 2'b10;
        st[0] = cyc + 2;
        run_cycles(50);
        check_grants("mask", 0, 0, 0);
        check("mask_done", done_cnt, 0);
        st[1] = cyc + 2;
        run_cycles(50);
        check_grants("mask1", 1, 2, 0);
        check("mask1_cnt", int'(frame_cnt), 1);
        src_en = 2'b11;

        // source 1 rises in the very cycle the block returns to idle
        do_reset();
        st = '{cyc + 2, cyc + 2 + FLEN + 1};
        run_cycles(100);
        check_grants("b2b", 2, 1, 2);
        check("b2b_cnt", int'(frame_cnt), 2);
        check("b2b_err", err_cnt, 0);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
